// File: rtl/detector_sched_pkg.sv
// rtl/detector_sched_pkg.sv - shared types and constants for the detector frame scheduler
package detector_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FRAME_W_DEF = 16;
    localparam int LEN_W_DEF   = 5;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter searching upward from a pointer
module rr_arbiter
    import detector_sched_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int IDX_W = clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any_req
);

    // Walk the offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int c;
        c       = 0;
        grant   = '0;
        idx     = '0;
        any_req = |req;
        for (int i = N_CH - 1; i >= 0; i--) begin
            c = (int'(ptr) + i) % N_CH;
            if (req[c]) begin
                idx = IDX_W'(c);
            end
        end
        if (any_req) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/detector_frame_scheduler.sv
// rtl/detector_frame_scheduler.sv - shares one serial pattern detector among channels, frame by frame
module detector_frame_scheduler
    import detector_sched_pkg::*;
#(
    parameter  int N_CH    = 4,
    parameter  int FRAME_W = FRAME_W_DEF,
    parameter  int LEN_W   = LEN_W_DEF,
    localparam int CH_W    = clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         req_valid,
    output logic [N_CH-1:0]         req_ready,
    input  logic [N_CH*FRAME_W-1:0] req_data,
    input  logic [N_CH*LEN_W-1:0]   req_len,
    output logic                    det_rst,
    output logic                    det_din,
    input  logic                    det_dout,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [CH_W-1:0]         rsp_ch,
    output logic [LEN_W-1:0]        rsp_count,
    output logic                    busy
);

    state_t             state;
    logic [CH_W-1:0]    rr_ptr;
    logic [CH_W-1:0]    cur_ch;
    logic [CH_W-1:0]    gnt_idx;
    logic [N_CH-1:0]    gnt;
    logic               any_req;
    logic               accept;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] sel_data;
    logic [LEN_W-1:0]   sel_len;
    logic [LEN_W-1:0]   clamp_len;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   bitcnt;
    logic [LEN_W-1:0]   cnt;

    rr_arbiter #(.N_CH(N_CH), .IDX_W(CH_W)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .grant   (gnt),
        .idx     (gnt_idx),
        .any_req (any_req)
    );

    always_comb begin
        sel_data = '0;
        sel_len  = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (gnt_idx == CH_W'(c)) begin
                sel_data = req_data[c*FRAME_W +: FRAME_W];
                sel_len  = req_len[c*LEN_W +: LEN_W];
            end
        end
        clamp_len = (sel_len > LEN_W'(FRAME_W)) ? LEN_W'(FRAME_W) : sel_len;
    end

    // Outputs are gated by rst so they read idle during a reset cycle whatever the prior state.
    assign accept    = (state == IDLE) && any_req && !rst;
    assign req_ready = accept ? gnt : '0;
    assign det_rst   = rst || (state == CLEAR);
    assign det_din   = !rst && (state == SHIFT) && shreg[0];
    assign busy      = !rst && (state != IDLE);
    assign rsp_valid = !rst && (state == DONE);
    assign rsp_ch    = rsp_valid ? cur_ch : '0;
    assign rsp_count = rsp_valid ? cnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cur_ch <= '0;
            shreg  <= '0;
            len    <= '0;
            bitcnt <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg  <= sel_data;
                        len    <= clamp_len;
                        cur_ch <= gnt_idx;
                        cnt    <= '0;
                        bitcnt <= '0;
                        rr_ptr <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
                        state  <= CLEAR;
                    end
                end
                CLEAR: begin
                    state <= (len != '0) ? SHIFT : DONE;
                end
                SHIFT: begin
                    cnt    <= cnt + LEN_W'(det_dout);
                    shreg  <= shreg >> 1;
                    bitcnt <= bitcnt + LEN_W'(1);
                    if (bitcnt == len - LEN_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_detector_frame_scheduler.sv
// tb/tb_detector_frame_scheduler.sv - scoreboard bench with a "1?1" detector and a frame-level reference model
module tb_detector_frame_scheduler;

    localparam int N_CH = 4;
    localparam int FW   = 16;
    localparam int LW   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_CH-1:0]   req_valid;
    logic [N_CH-1:0]   req_ready;
    logic [N_CH*FW-1:0] req_data;
    logic [N_CH*LW-1:0] req_len;
    logic              det_rst;
    logic              det_din;
    logic              det_dout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_ch;
    logic [LW-1:0]     rsp_count;
    logic              busy;

    always #5 clk = ~clk;

    detector_frame_scheduler #(.N_CH(N_CH), .FRAME_W(FW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_len   (req_len),
        .det_rst   (det_rst),
        .det_din   (det_din),
        .det_dout  (det_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_ch    (rsp_ch),
        .rsp_count (rsp_count),
        .busy      (busy)
    );

    // External detector: Mealy pulse when din is 1 and the bit two cycles earlier was 1.
    logic [1:0] hist;
    assign det_dout = det_din & hist[1];
    always @(posedge clk) hist <= det_rst ? 2'b00 : {hist[0], det_din};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ch;
        int count;
        int due;
    } rsp_t;
    rsp_t exp_q[$];

    int            m_ptr  = 0;
    bit            m_busy = 1'b0;
    int            m_acc  = 0;
    int            m_len  = 0;
    int            m_due  = 0;
    logic [FW-1:0] m_frame;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int ref_count(input logic [FW-1:0] f, input int len);
        int n;
        n = 0;
        for (int i = 2; i < len; i++) begin
            if (f[i] && f[i-2]) n++;
        end
        return n;
    endfunction

    // Reference model: arbitration, detector control timing, and response prediction.
    initial begin : model
        logic [N_CH-1:0] exp_rdy;
        int              g;
        logic            exp_din;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_det_rst", 32'(det_rst), 32'd1);
                check("rst_req_ready", 32'(req_ready), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_det_din", 32'(det_din), 32'd0);
                m_ptr  = 0;
                m_busy = 1'b0;
            end else begin
                exp_rdy = '0;
                g       = -1;
                if (!m_busy) begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (g < 0 && req_valid[(m_ptr + k) % N_CH]) g = (m_ptr + k) % N_CH;
                    end
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
                check("req_ready", 32'(req_ready), 32'(exp_rdy));
                check("busy", 32'(busy), 32'(m_busy));
                check("det_rst", 32'(det_rst), 32'(m_busy && cyc == m_acc + 1));
                exp_din = 1'b0;
                if (m_busy && cyc >= m_acc + 2 && cyc < m_acc + 2 + m_len) exp_din = m_frame[cyc - m_acc - 2];
                check("det_din", 32'(det_din), 32'(exp_din));
                if (m_busy && cyc >= m_due && rsp_ready) begin
                    m_busy = 1'b0;
                end else if (g >= 0) begin
                    m_frame = req_data[g*FW +: FW];
                    m_len   = int'(req_len[g*LW +: LW]);
                    if (m_len > FW) m_len = FW;
                    m_acc   = cyc;
                    m_due   = cyc + 2 + m_len;
                    m_busy  = 1'b1;
                    m_ptr   = (g + 1) % N_CH;
                    exp_q.push_back('{g, ref_count(m_frame, m_len), m_due});
                end
            end
        end
    end

    initial begin : monitor
        logic exp_v;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                check("rst_rsp_ch", 32'(rsp_ch), 32'd0);
                check("rst_rsp_count", 32'(rsp_count), 32'd0);
                exp_q.delete();
            end else begin
                exp_v = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
                check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
                if (exp_v) begin
                    check("rsp_ch", 32'(rsp_ch), 32'(exp_q[0].ch));
                    check("rsp_count", 32'(rsp_count), 32'(exp_q[0].count));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic set_ch(input int ch, input logic [FW-1:0] d, input logic [LW-1:0] l);
        req_data[ch*FW +: FW] = d;
        req_len[ch*LW +: LW]  = l;
    endtask

    task automatic wait_grant(input int ch);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (req_ready[ch]) got = 1'b1;
        end
        check("grant_wait", 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [FW-1:0] d, input logic [LW-1:0] l);
        set_ch(ch, d, l);
        req_valid[ch] = 1'b1;
        wait_grant(ch);
        req_valid[ch] = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(negedge clk);
            #1;
            if (!m_busy && exp_q.size() == 0) idle = 1'b1;
        end
        check("idle_wait", 32'(idle), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_len   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        send(0, 16'h006F, 5'd8);
        wait_idle();
        send(1, 16'h0005, 5'd3);
        wait_idle();
        send(1, 16'h0001, 5'd1);
        wait_idle();
        send(1, 16'h0001, 5'd1);
        wait_idle();

        rst = 1'b1;
        for (int c = 0; c < N_CH; c++) set_ch(c, 16'($urandom), 5'd4);
        req_valid = '1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1 req_valid = '0;
        wait_idle();

        send(2, 16'($urandom), 5'd0);
        wait_idle();
        send(3, 16'hA5C3, 5'd31);
        wait_idle();

        rsp_ready = 1'b0;
        send(0, 16'($urandom), 5'd4);
        for (int c = 1; c < N_CH; c++) set_ch(c, 16'($urandom), 5'd2);
        req_valid = 4'b1110;
        repeat (26) @(posedge clk);
        #1 rsp_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1 req_valid = '0;
        wait_idle();

        send(1, 16'($urandom), 5'd16);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        set_ch(0, 16'($urandom), 5'd6);
        set_ch(2, 16'($urandom), 5'd6);
        req_valid = 4'b0101;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = '0;
        wait_idle();

        for (int n = 0; n < 1500; n++) begin
            req_valid = N_CH'($urandom);
            for (int c = 0; c < N_CH; c++) set_ch(c, 16'($urandom), 5'($urandom_range(0, 20)));
            rsp_ready = ($urandom % 4) != 0;
            rst       = ($urandom % 250) == 0;
            @(posedge clk);
            #1;
        end
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
